p_mul_seq: RTL and testbench
============================

Name: p_mul_seq

Overview:
- Sequential packed unsigned multiplier for the packed-arithmetic unit.
- Consumes the packed adder `p_addsub`. It instantiates `p_addsub` and iterates shift-add over every lane in parallel.
- For lane width w, produces the packed low halves and packed high halves of the 2w-bit per-lane products.
- Sits in the execute stage beside the combinational packed ALU ops and serves the multi-cycle packed-multiply instructions.

Parameters:
- None. Datapath fixed at 32 bits, lane widths 32/16/8/4/2.

Ports:
- `g_clk` input 1: clock.
- `g_reset` input 1: synchronous, active-high reset.
- `valid` input 1: request; held high until `ready` is seen.
- `lhs` input 32: multiplicand, packed.
- `rhs` input 32: multiplier, packed.
- `pw` input 5: one-hot pack width; bit0=32, bit1=16, bit2=8, bit3=4, bit4=2.
- `ready` output 1: one-cycle pulse; results valid in that cycle.
- `busy` output 1: high while an operation is in progress (state RUN).
- `result_lo` output 32: packed low halves of the lane products.
- `result_hi` output 32: packed high halves of the lane products.

Behaviour:
- Clock and reset: one clock `g_clk`; reset `g_reset` is synchronous and active-high.
- Reset values: state IDLE, `ready`=0, `busy`=0, `result_lo`=0, `result_hi`=0, counter=0.
- Lane width decode: `pw` is priority-decoded, lowest set index wins. `pw`=0 is treated as 32-bit.
- Registers: `mcand` (32), `acc_hi` (32), `acc_lo` (32), 6-bit step counter.
- IDLE:
  - If `valid`=1: `mcand`<=`lhs`, `acc_lo`<=`rhs`, `acc_hi`<=0, counter<=w; go to RUN.
  - This is the accepting cycle T.
- RUN, one step per cycle, all lanes in parallel:
  - Lane addend = that lane of `mcand` if the LSB of the `acc_lo` lane is 1, else 0.
  - `p_addsub` computes `acc_hi` + addend with `sub`=0, `cin`=0, `c_en`=1 and the decoded `pw`.
  - Lane carry-out c = the adder carry at the lane MSB.
  - Each lane's {c, sum, `acc_lo` lane} is shifted right 1 bit, independently per lane. No bits cross a lane boundary.
  - Counter decrements. When it reaches 0, copy `acc_lo`/`acc_hi` into `result_lo`/`result_hi` and go to DONE.
- DONE: `ready`=1 for exactly one cycle, then IDLE.
  - Latency: `ready` is asserted in cycle T+w+1, i.e. 33/17/9/5/3 cycles after acceptance.
- Outputs hold: `result_lo` and `result_hi` hold their values after DONE until the next completion.
- Operand stability: `lhs`, `rhs` and `pw` are captured at T. Changes during RUN are ignored.
- Abort: `valid` falling during RUN returns the FSM to IDLE on the next edge.
  - No `ready` is produced and results are not updated.
- Back-to-back requests: if `valid` is still high in the cycle after `ready`, the FSM is in IDLE and accepts it as a new request. The requester must drop `valid` in the `ready` cycle to avoid a repeat.
- Reset mid-operation: returns to reset values on the next edge; no `ready`.
- `busy` = (state==RUN).

Optional Feature:
- Macro: `P_MUL_SEQ_CLMUL_EN`.
- When defined:
  - Adds input port `clmul` (1 bit), captured at acceptance.
  - When `clmul`=1, the per-step addition is replaced by lane-wise XOR and c is forced to 0. This gives packed carry-less products, with the same latency.
- When undefined: no `clmul` port; always integer multiply.

Decomposition:
- Shared package (`p_pkg`):
  - Pack-width one-hot index constants.
  - Lane-width lookup (pw to w).
  - FSM state encoding IDLE/RUN/DONE.
- Sub-modules: none new. The design reuses one instance of `p_addsub`.
- Lane-MSB carry selection and per-lane shift are local generate logic.

Test Plan:
- pw=32 (`pw`=5'b00001), `lhs`=`rhs`=0xFFFFFFFF → `result_hi`=0xFFFFFFFE, `result_lo`=0x00000001, `ready` at T+33.
- pw=8, `lhs`=0x02030405, `rhs`=0x10101010 → `result_lo`=0x20304050, `result_hi`=0x00000000, `ready` at T+9.
- pw=2, `lhs`=`rhs`=0xFFFFFFFF → `result_lo`=0x55555555, `result_hi`=0xAAAAAAAA, `ready` at T+3.
- pw=16, `lhs`=0x8000FFFF, `rhs`=0x00020003 → `result_lo`=0x0000FFFD, `result_hi`=0x00010002, `ready` at T+17.
- Abort and reset:
  - pw=32, drop `valid` at T+5 → no `ready`, `busy`=0 at T+6, results unchanged.
  - Assert `g_reset` at T+10 of a new operation → all outputs 0.
  - A subsequent request yields the correct product.
- With `P_MUL_SEQ_CLMUL_EN`, pw=8, `lhs`=`rhs`=0x03030303:
  - `clmul`=1 → `result_lo`=0x05050505, `result_hi`=0.
  - `clmul`=0 → `result_lo`=0x09090909.

Source files
------------

// File: rtl/p_pkg.sv
// Shared definitions for the packed-arithmetic unit: pack-width one-hot
// indices, the pw -> lane-width lookup and the multiplier FSM encoding.
package p_pkg;

    // Bit positions inside the one-hot pack-width field.
    localparam int unsigned PW_32_IDX = 0;
    localparam int unsigned PW_16_IDX = 1;
    localparam int unsigned PW_8_IDX  = 2;
    localparam int unsigned PW_4_IDX  = 3;
    localparam int unsigned PW_2_IDX  = 4;

    // Multiplier FSM encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Priority decode: lowest set bit wins, all-zero means 32-bit lanes.
    function automatic logic [5:0] lane_width(input logic [4:0] pw);
        if (pw[PW_32_IDX]) begin
            return 6'd32;
        end else if (pw[PW_16_IDX]) begin
            return 6'd16;
        end else if (pw[PW_8_IDX]) begin
            return 6'd8;
        end else if (pw[PW_4_IDX]) begin
            return 6'd4;
        end else if (pw[PW_2_IDX]) begin
            return 6'd2;
        end else begin
            return 6'd32;
        end
    endfunction

endpackage

// File: rtl/p_addsub.sv
// Packed adder/subtractor. Carries ripple only inside a lane; every lane
// starts from (cin | sub). With c_en=0 no carry propagates, so the result
// is a plain lane-wise XOR. carry[i] is the carry out of bit i.
module p_addsub
    import p_pkg::*;
(
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    input  logic [4:0]  pw,
    input  logic        sub,
    input  logic        cin,
    input  logic        c_en,
    output logic [31:0] result,
    output logic [31:0] carry
);

    logic [5:0] w;
    logic       c;
    logic       b;
    logic       g;

    // Ripple through all 32 bits, restarting the carry at each lane LSB.
    always_comb begin
        w      = lane_width(pw);
        c      = 1'b0;
        b      = 1'b0;
        g      = 1'b0;
        result = '0;
        carry  = '0;
        for (int i = 0; i < 32; i++) begin
            b = rhs[i] ^ sub;
            if ((i & (int'(w) - 1)) == 0) begin
                c = cin | sub;
            end
            result[i] = lhs[i] ^ b ^ c;
            g         = (lhs[i] & b) | (c & (lhs[i] ^ b));
            carry[i]  = g & c_en;
            c         = g & c_en;
        end
    end

endmodule

// File: rtl/p_mul_seq.sv
// Sequential packed unsigned multiplier. Runs one shift-add step per cycle
// on all lanes at once using a single p_addsub; after w steps acc_hi/acc_lo
// hold the high/low halves of every 2w-bit lane product.
// Optional P_MUL_SEQ_CLMUL_EN adds a 'clmul' input selecting carry-less
// (XOR) accumulation with identical latency.
module p_mul_seq
    import p_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        valid,
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    input  logic [4:0]  pw,
`ifdef P_MUL_SEQ_CLMUL_EN
    input  logic        clmul,
`endif
    output logic        ready,
    output logic        busy,
    output logic [31:0] result_lo,
    output logic [31:0] result_hi
);

    logic [1:0]  state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [4:0]  pw_q, pw_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic        clmul_q;

    logic [5:0]  w;
    logic [31:0] addend;
    logic [31:0] sum;
    logic [31:0] carry;
    logic [32:0] sum_x;
    logic [32:0] lo_x;
    logic [31:0] hi_n;
    logic [31:0] lo_n;

`ifdef P_MUL_SEQ_CLMUL_EN
    // Carry-less mode is latched with the operands at acceptance.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            clmul_q <= 1'b0;
        end else if (state_q == ST_IDLE && valid) begin
            clmul_q <= clmul;
        end
    end
`else
    assign clmul_q = 1'b0;
`endif

    assign w = lane_width(pw_q);

    // Each lane adds its multiplicand only when its multiplier LSB is set.
    always_comb begin
        addend = '0;
        for (int i = 0; i < 32; i++) begin
            addend[i] = mcand_q[i] & acc_lo_q[i & ~(int'(w) - 1)];
        end
    end

    p_addsub u_addsub (
        .lhs    (acc_hi_q),
        .rhs    (addend),
        .pw     (pw_q),
        .sub    (1'b0),
        .cin    (1'b0),
        .c_en   (~clmul_q),
        .result (sum),
        .carry  (carry)
    );

    // Per-lane right shift of {c, sum, acc_lo}; nothing crosses a lane edge.
    always_comb begin
        sum_x = {1'b0, sum};
        lo_x  = {1'b0, acc_lo_q};
        hi_n  = '0;
        lo_n  = '0;
        for (int i = 0; i < 32; i++) begin
            if (i == ((i & ~(int'(w) - 1)) + int'(w) - 1)) begin
                hi_n[i] = carry[i] & ~clmul_q;
                lo_n[i] = sum[i & ~(int'(w) - 1)];
            end else begin
                hi_n[i] = sum_x[i + 1];
                lo_n[i] = lo_x[i + 1];
            end
        end
    end

    // Next-state: accept, step/abort, and one-cycle completion pulse.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        pw_d     = pw_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    mcand_d  = lhs;
                    acc_lo_d = rhs;
                    acc_hi_d = '0;
                    cnt_d    = lane_width(pw);
                    pw_d     = pw;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!valid) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_hi_d = hi_n;
                    acc_lo_d = lo_n;
                    cnt_d    = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        res_lo_d = lo_n;
                        res_hi_d = hi_n;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            pw_q     <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
            pw_q     <= pw_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
        end
    end

    assign ready     = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN);
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;

endmodule

// File: tb/tb_p_mul_seq.sv
// Self-checking bench for p_mul_seq: directed vectors, randomized operations
// against a lane-by-lane arithmetic model, abort and mid-operation reset.
// Carry-less vectors are included when P_MUL_SEQ_CLMUL_EN is defined.
module tb_p_mul_seq;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        valid;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [4:0]  pw;
    logic        ready;
    logic        busy;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
`ifdef P_MUL_SEQ_CLMUL_EN
    logic        clmul;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] last_lo;
    logic [31:0] last_hi;

    always #5 g_clk = ~g_clk;

    p_mul_seq dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .valid     (valid),
        .lhs       (lhs),
        .rhs       (rhs),
        .pw        (pw),
`ifdef P_MUL_SEQ_CLMUL_EN
        .clmul     (clmul),
`endif
        .ready     (ready),
        .busy      (busy),
        .result_lo (result_lo),
        .result_hi (result_hi)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int lane_w(input logic [4:0] p);
        if (p[0]) return 32;
        if (p[1]) return 16;
        if (p[2]) return 8;
        if (p[3]) return 4;
        if (p[4]) return 2;
        return 32;
    endfunction

    // Reference: split into lanes, form each 2w-bit product arithmetically.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] p,
                         input bit cl, output logic [31:0] lo, output logic [31:0] hi);
        int          w;
        logic [63:0] mask, x, y, prod;
        w    = lane_w(p);
        mask = (64'd1 << w) - 64'd1;
        lo   = '0;
        hi   = '0;
        for (int l = 0; l < 32 / w; l++) begin
            x = (64'(a) >> (l * w)) & mask;
            y = (64'(b) >> (l * w)) & mask;
            if (cl) begin
                prod = '0;
                for (int j = 0; j < w; j++) begin
                    if (y[j]) prod = prod ^ (x << j);
                end
            end else begin
                prod = x * y;
            end
            lo = lo | 32'((prod & mask) << (l * w));
            hi = hi | 32'(((prod >> w) & mask) << (l * w));
        end
    endtask

    // One request: accept, scramble inputs while running, check latency and results.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] p,
                          input bit cl, input string tag);
        logic [31:0] exp_lo, exp_hi;
        int          lat;
        model(a, b, p, cl, exp_lo, exp_hi);
        @(negedge g_clk);
        valid = 1'b1;
        lhs   = a;
        rhs   = b;
        pw    = p;
`ifdef P_MUL_SEQ_CLMUL_EN
        clmul = cl;
`endif
        @(posedge g_clk);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge g_clk);
            if (ready) begin
                lat = k;
                break;
            end
            if (k == 1) check({tag, "_busy_run"}, 32'(busy), 32'd1);
            lhs = $urandom;
            rhs = $urandom;
            pw  = 5'($urandom);
`ifdef P_MUL_SEQ_CLMUL_EN
            clmul = ~cl;
`endif
        end
        check({tag, "_latency"}, 32'(lat), 32'(lane_w(p) + 1));
        if (lat != 0) begin
            check({tag, "_busy_done"}, 32'(busy), 32'd0);
            check({tag, "_lo"}, result_lo, exp_lo);
            check({tag, "_hi"}, result_hi, exp_hi);
        end
        valid = 1'b0;
        @(negedge g_clk);
        check({tag, "_ready_pulse"}, 32'(ready), 32'd0);
        check({tag, "_hold_lo"}, result_lo, exp_lo);
        check({tag, "_hold_hi"}, result_hi, exp_hi);
        last_lo = exp_lo;
        last_hi = exp_hi;
    endtask

    initial begin
        int seen;
        g_reset = 1'b1;
        valid   = 1'b0;
        lhs     = '0;
        rhs     = '0;
        pw      = '0;
`ifdef P_MUL_SEQ_CLMUL_EN
        clmul   = 1'b0;
`endif
        repeat (3) @(negedge g_clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_lo", result_lo, 32'd0);
        check("rst_hi", result_hi, 32'd0);
        g_reset = 1'b0;

        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00001, 1'b0, "w32_ones");
        run_op(32'h02030405, 32'h10101010, 5'b00100, 1'b0, "w8_vec");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 5'b10000, 1'b0, "w2_ones");
        run_op(32'h8000FFFF, 32'h00020003, 5'b00010, 1'b0, "w16_vec");
        run_op(32'h12345678, 32'h9ABCDEF0, 5'b00000, 1'b0, "pw_zero");
        run_op(32'hDEADBEEF, 32'hCAFEF00D, 5'b11100, 1'b0, "pw_prio");

        // Abort: drop valid in cycle T+5.
        @(negedge g_clk);
        valid = 1'b1;
        lhs   = $urandom;
        rhs   = $urandom;
        pw    = 5'b00001;
        @(posedge g_clk);
        for (int k = 1; k <= 5; k++) @(negedge g_clk);
        valid = 1'b0;
        @(negedge g_clk);
        check("abort_busy", 32'(busy), 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge g_clk);
            if (ready) seen++;
        end
        check("abort_no_ready", 32'(seen), 32'd0);
        check("abort_lo", result_lo, last_lo);
        check("abort_hi", result_hi, last_hi);

        // Reset in cycle T+10 of a new operation.
        @(negedge g_clk);
        valid = 1'b1;
        lhs   = $urandom;
        rhs   = $urandom;
        pw    = 5'b00001;
        @(posedge g_clk);
        for (int k = 1; k <= 10; k++) @(negedge g_clk);
        g_reset = 1'b1;
        valid   = 1'b0;
        @(negedge g_clk);
        check("mrst_ready", 32'(ready), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_lo", result_lo, 32'd0);
        check("mrst_hi", result_hi, 32'd0);
        g_reset = 1'b0;
        run_op(32'h0000FFFF, 32'h00010001, 5'b00010, 1'b0, "post_rst");

`ifdef P_MUL_SEQ_CLMUL_EN
        run_op(32'h03030303, 32'h03030303, 5'b00100, 1'b1, "clmul_w8");
        run_op(32'h03030303, 32'h03030303, 5'b00100, 1'b0, "int_w8");
`endif

        for (int n = 0; n < 40; n++) begin
            bit cl;
            cl = 1'b0;
`ifdef P_MUL_SEQ_CLMUL_EN
            cl = 1'($urandom);
`endif
            run_op($urandom, $urandom, 5'($urandom), cl, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
